// File: rtl/nios2_pio_irq_ctrl_if.sv
// Avalon-MM slave bus bundle for the debounced PIO interrupt controller.
interface nios2_pio_irq_ctrl_if;
  logic [1:0]  address;
  logic        chipselect;
  logic        write_n;
  logic [31:0] writedata;
  logic [31:0] readdata;

  modport master (
    output address,
    output chipselect,
    output write_n,
    output writedata,
    input  readdata
  );

  modport slave (
    input  address,
    input  chipselect,
    input  write_n,
    input  writedata,
    output readdata
  );
endinterface

// File: rtl/nios2_pio_irq_ctrl.sv
// Debounced input PIO with edge capture and maskable level IRQ for the Nios II.
// Optional: define NIOS2_PIO_IRQ_BOTH_EDGE_EN to capture falling edges as well as rising.
module nios2_pio_irq_ctrl #(
  parameter int WIDTH        = 10,
  parameter int CNT_W        = 16,
  parameter int DEBOUNCE_RST = 50000
) (
  input  logic                  clk,
  input  logic                  reset,
  nios2_pio_irq_ctrl_if.slave   bus,
  input  logic [WIDTH-1:0]      in_port,
  output logic                  irq
);

  localparam logic [0:0]       ST_STABLE  = 1'b0;
  localparam logic [0:0]       ST_SETTLE  = 1'b1;
  localparam logic [CNT_W-1:0] RELOAD_RST = CNT_W'(DEBOUNCE_RST);

  logic [WIDTH-1:0] sync_p0;
  logic [WIDTH-1:0] sync_p1;
  logic [WIDTH-1:0] stable;
  logic [WIDTH-1:0] cand;
  logic [CNT_W-1:0] cnt;
  logic [0:0]       state;
  logic [WIDTH-1:0] irqmask;
  logic [WIDTH-1:0] edgecapture;
  logic [CNT_W-1:0] reload;

  logic             wr_en;
  logic [CNT_W-1:0] eff_m1;
  logic             commit;
  logic [WIDTH-1:0] edge_set;
  logic [WIDTH-1:0] ec_clr;
  logic [31:0]      rd_mux;

  assign wr_en = bus.chipselect & ~bus.write_n;

  // reload of 0 is treated as 1; a counter already past the limit commits at once
  assign eff_m1 = (reload == '0) ? '0 : reload - CNT_W'(1);
  assign commit = (state == ST_SETTLE) && (sync_p1 == cand) && (cnt >= eff_m1);

`ifdef NIOS2_PIO_IRQ_BOTH_EDGE_EN
  assign edge_set = commit ? (cand ^ stable) : '0;
`else
  assign edge_set = commit ? (cand & ~stable) : '0;
`endif

  assign ec_clr = (wr_en && bus.address == 2'd2) ? bus.writedata[WIDTH-1:0] : '0;

  // stage p0/p1: two-flop synchronizer
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync_p0 <= '0;
      sync_p1 <= '0;
    end else begin
      sync_p0 <= in_port;
      sync_p1 <= sync_p0;
    end
  end

  // debounce: one shared counter, all bits commit together
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state  <= ST_STABLE;
      stable <= '0;
      cand   <= '0;
      cnt    <= '0;
    end else begin
      case (state)
        ST_STABLE: begin
          if (sync_p1 != stable) begin
            cand  <= sync_p1;
            cnt   <= '0;
            state <= ST_SETTLE;
          end
        end
        ST_SETTLE: begin
          if (sync_p1 != cand) begin
            cand <= sync_p1;
            cnt  <= '0;
            if (sync_p1 == stable) state <= ST_STABLE;
          end else if (commit) begin
            stable <= cand;
            state  <= ST_STABLE;
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end
        default: state <= ST_STABLE;
      endcase
    end
  end

  // register file; a capture in the same cycle as its W1C wins
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      irqmask     <= '0;
      edgecapture <= '0;
      reload      <= RELOAD_RST;
      irq         <= 1'b0;
    end else begin
      if (wr_en && bus.address == 2'd1) irqmask <= bus.writedata[WIDTH-1:0];
      if (wr_en && bus.address == 2'd3) reload  <= bus.writedata[CNT_W-1:0];
      edgecapture <= (edgecapture & ~ec_clr) | edge_set;
      irq         <= |(edgecapture & irqmask);
    end
  end

  always_comb begin
    rd_mux = '0;
    case (bus.address)
      2'd0:    rd_mux = 32'(stable);
      2'd1:    rd_mux = 32'(irqmask);
      2'd2:    rd_mux = 32'(edgecapture);
      default: rd_mux = 32'(reload);
    endcase
  end

  // stage p2: registered read port
  always_ff @(posedge clk or posedge reset) begin
    if (reset) bus.readdata <= '0;
    else       bus.readdata <= rd_mux;
  end

endmodule
